// File: rtl/cpu_pkg.sv
// Shared CPU definitions: next-PC mode encodings and the default instruction step.
package cpu_pkg;

   // Default byte increment per instruction.
   localparam int PC_STEP = 4;

   // Next-PC source select driven by the decoder; codes 6 and 7 fall back to sequential.
   typedef enum logic [2:0] {
      PC_SEQ  = 3'd0,
      PC_BR   = 3'd1,
      PC_JMP  = 3'd2,
      PC_CALL = 3'd3,
      PC_RET  = 3'd4,
      PC_JR   = 3'd5
   } pc_mode_e;

endpackage

// File: rtl/ras_stack.sv
// Return-address stack: circular register array with a top pointer and occupancy count.
// A push when full overwrites the oldest entry; a pop when empty changes nothing.
module ras_stack #(
   parameter int ADDR_W    = 32,
   parameter int RAS_DEPTH = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              push,
   input  logic              pop,
   input  logic [ADDR_W-1:0] push_data,
   output logic [ADDR_W-1:0] top_data,
   output logic              empty,
   output logic              full,
   output logic              ovf,
   output logic              unf
);

   localparam int PTR_W = $clog2(RAS_DEPTH);
   localparam logic [PTR_W:0] DEPTH_CNT = (PTR_W+1)'(RAS_DEPTH);

   logic [ADDR_W-1:0] mem [RAS_DEPTH];
   logic [PTR_W-1:0]  ptr;
   logic [PTR_W:0]    count;
   logic [PTR_W-1:0]  wr_idx;

   // When full, the slot after the top is the oldest entry, so it is the one overwritten.
   assign wr_idx   = ptr + 1'b1;
   assign top_data = mem[ptr];
   assign empty    = (count == '0);
   assign full     = (count == DEPTH_CNT);
   assign ovf      = push & full;
   assign unf      = pop & empty;

   // Pointer and occupancy update; push and pop are never requested together.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      if (reset) begin
         ptr   <= '0;
         count <= '0;
      end else if (push) begin
         ptr <= wr_idx;
         if (!full) count <= count + 1'b1;
      end else if (pop && !empty) begin
         ptr   <= ptr - 1'b1;
         count <= count - 1'b1;
      end
   end

   // Entry storage write.
   always_ff @(posedge clk) begin
      // NOTE: the array is deliberately not reset; stale entries are unreachable once count is zero.
      if (push) mem[wr_idx] <= push_data;
   end

endmodule

// File: rtl/pc_seq_unit.sv
// Program-counter sequencer: next-PC mux, sequential/relative adders, PC register,
// return-address stack and sticky RAS error flag. BUSY freezes all state.
module pc_seq_unit
   import cpu_pkg::*;
#(
   parameter int              ADDR_W    = 32,
   parameter int              STEP      = PC_STEP,
   parameter logic [ADDR_W-1:0] RESET_VEC = '0 - ADDR_W'(STEP),
   parameter int              RAS_DEPTH = 4
) (
   input  logic              CLK,
   input  logic              RESET,
   input  logic              BUSY,
   input  logic [2:0]        MODE,
   input  logic              TAKEN,
   input  logic [ADDR_W-1:0] OFFSET,
   input  logic [ADDR_W-1:0] TARGET,
   output logic [ADDR_W-1:0] PC_OUT,
   output logic              RAS_EMPTY,
   output logic              RAS_FULL,
   output logic              RAS_ERR
);

   logic [ADDR_W-1:0] seq_pc;
   logic [ADDR_W-1:0] rel_pc;
   logic [ADDR_W-1:0] next_pc;
   logic [ADDR_W-1:0] top_data;
   logic              push;
   logic              pop;
   logic              ovf;
   logic              unf;

   // Carries out of the top bit are dropped; PC arithmetic wraps.
   assign seq_pc = PC_OUT + ADDR_W'(STEP);
   assign rel_pc = seq_pc + OFFSET;

   // Next-PC selection and stack requests; requests are suppressed while memory is busy.
   always_comb begin
      // NOTE: every output gets a default first so no path leaves a value unassigned (no latch).
      next_pc = seq_pc;
      push    = 1'b0;
      pop     = 1'b0;
      case (MODE)
         PC_BR:   next_pc = TAKEN ? rel_pc : seq_pc;
         PC_JMP:  next_pc = rel_pc;
         PC_CALL: begin
            next_pc = rel_pc;
            push    = !BUSY;
         end
         PC_RET:  begin
            next_pc = RAS_EMPTY ? seq_pc : top_data;
            pop     = !BUSY;
         end
         PC_JR:   next_pc = TARGET;
         default: next_pc = seq_pc;
      endcase
   end

   ras_stack #(
      .ADDR_W    (ADDR_W),
      .RAS_DEPTH (RAS_DEPTH)
   ) u_ras (
      .clk       (CLK),
      .reset     (RESET),
      .push      (push),
      .pop       (pop),
      .push_data (seq_pc),
      .top_data  (top_data),
      .empty     (RAS_EMPTY),
      .full      (RAS_FULL),
      .ovf       (ovf),
      .unf       (unf)
   );

   // PC register and sticky error flag; reset wins over BUSY, BUSY holds everything.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         PC_OUT  <= RESET_VEC;
         RAS_ERR <= 1'b0;
      end else if (!BUSY) begin
         PC_OUT  <= next_pc;
         RAS_ERR <= RAS_ERR | ovf | unf;
      end
   end

endmodule

// File: tb/tb_pc_seq_unit.sv
// Self-checking bench for pc_seq_unit: directed scenarios plus randomized traffic,
// compared every cycle against a queue-based reference model of the sequencer.
module tb_pc_seq_unit;

   localparam int DEPTH = 4;

   logic        CLK = 1'b0;
   logic        RESET = 1'b1;
   logic        BUSY = 1'b0;
   logic [2:0]  MODE = 3'd0;
   logic        TAKEN = 1'b0;
   logic [31:0] OFFSET = '0;
   logic [31:0] TARGET = '0;
   logic [31:0] PC_OUT;
   logic        RAS_EMPTY;
   logic        RAS_FULL;
   logic        RAS_ERR;

   int n_cmp = 0;
   int n_err = 0;

   // Reference model state.
   logic [31:0] m_pc;
   logic [31:0] m_ras[$];
   bit          m_err;

   pc_seq_unit dut (
      .CLK       (CLK),
      .RESET     (RESET),
      .BUSY      (BUSY),
      .MODE      (MODE),
      .TAKEN     (TAKEN),
      .OFFSET    (OFFSET),
      .TARGET    (TARGET),
      .PC_OUT    (PC_OUT),
      .RAS_EMPTY (RAS_EMPTY),
      .RAS_FULL  (RAS_FULL),
      .RAS_ERR   (RAS_ERR)
   );

   always #5 CLK = ~CLK;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   // Reference behaviour for one clock edge, straight from the sequencing rules.
   task automatic model_edge(input bit rst, input bit busy, input logic [2:0] mode,
                             input bit taken, input logic [31:0] off, input logic [31:0] tgt);
      logic [31:0] seq, rel;
      seq = m_pc + 32'd4;
      rel = seq + off;
      if (rst) begin
         m_pc = 32'hFFFF_FFFC;
         m_ras.delete();
         m_err = 1'b0;
      end else if (!busy) begin
         case (mode)
            3'd1: m_pc = taken ? rel : seq;
            3'd2: m_pc = rel;
            3'd3: begin
               if (m_ras.size() == DEPTH) begin
                  void'(m_ras.pop_front());
                  m_err = 1'b1;
               end
               m_ras.push_back(seq);
               m_pc = rel;
            end
            3'd4: begin
               if (m_ras.size() == 0) begin
                  m_err = 1'b1;
                  m_pc  = seq;
               end else begin
                  m_pc = m_ras.pop_back();
               end
            end
            3'd5: m_pc = tgt;
            default: m_pc = seq;
         endcase
      end
   endtask

   // Drive one cycle of inputs, advance model and DUT, then compare on the falling edge.
   task automatic step(input bit rst, input bit busy, input logic [2:0] mode,
                       input bit taken, input logic [31:0] off, input logic [31:0] tgt);
      RESET  = rst;
      BUSY   = busy;
      MODE   = mode;
      TAKEN  = taken;
      OFFSET = off;
      TARGET = tgt;
      @(posedge CLK);
      model_edge(rst, busy, mode, taken, off, tgt);
      @(negedge CLK);
      check("pc", PC_OUT, m_pc);
      check("empty", {31'd0, RAS_EMPTY}, {31'd0, m_ras.size() == 0});
      check("full", {31'd0, RAS_FULL}, {31'd0, m_ras.size() == DEPTH});
      check("err", {31'd0, RAS_ERR}, {31'd0, m_err});
   endtask

   initial begin
      logic [31:0] held_pc;

      // Reset, then three sequential fetches: FFFFFFFC -> 0 -> 4 -> 8.
      step(1, 0, 3'd0, 0, 0, 0);
      check("reset_pc", PC_OUT, 32'hFFFF_FFFC);
      step(0, 0, 3'd0, 0, 0, 0);
      check("first_fetch", PC_OUT, 32'h0);
      step(0, 0, 3'd0, 0, 0, 0);
      step(0, 0, 3'd0, 0, 0, 0);
      check("seq_8", PC_OUT, 32'h8);

      // Branch and register-jump cases from PC=0x10.
      step(0, 0, 3'd5, 0, 0, 32'h10);
      step(0, 0, 3'd1, 0, 32'h20, 0);
      check("br_not_taken", PC_OUT, 32'h14);
      step(0, 0, 3'd5, 0, 0, 32'h10);
      step(0, 0, 3'd1, 1, 32'hFFFF_FFF8, 0);
      check("br_taken_back", PC_OUT, 32'h0C);
      step(0, 0, 3'd5, 0, 0, 32'h10);
      step(0, 0, 3'd5, 0, 0, 32'h100);
      check("jr", PC_OUT, 32'h100);

      // BUSY stalls a CALL for three cycles, then exactly one push happens.
      held_pc = PC_OUT;
      for (int i = 0; i < 3; i++) step(0, 1, 3'd3, 0, 32'h40, 0);
      check("busy_hold_pc", PC_OUT, held_pc);
      step(0, 0, 3'd3, 0, 32'h40, 0);
      check("call_after_busy", PC_OUT, held_pc + 32'h44);
      step(0, 0, 3'd4, 0, 0, 0);
      check("single_push_ret", PC_OUT, held_pc + 32'h4);
      check("single_push_empty", {31'd0, RAS_EMPTY}, 32'd1);

      // Nested calls from 0x00/0x40/0x80 and matching returns.
      step(1, 0, 3'd0, 0, 0, 0);
      step(0, 0, 3'd0, 0, 0, 0);
      for (int i = 0; i < 3; i++) step(0, 0, 3'd3, 0, 32'h3C, 0);
      step(0, 0, 3'd4, 0, 0, 0);
      check("ret_1", PC_OUT, 32'h84);
      step(0, 0, 3'd4, 0, 0, 0);
      check("ret_2", PC_OUT, 32'h44);
      step(0, 0, 3'd4, 0, 0, 0);
      check("ret_3", PC_OUT, 32'h04);
      check("chain_no_err", {31'd0, RAS_ERR}, 32'd0);

      // Five calls overflow a four-deep stack; oldest return address is lost.
      step(1, 0, 3'd0, 0, 0, 0);
      step(0, 0, 3'd0, 0, 0, 0);
      for (int i = 0; i < 5; i++) step(0, 0, 3'd3, 0, 32'h100, 0);
      check("ovf_full", {31'd0, RAS_FULL}, 32'd1);
      check("ovf_err", {31'd0, RAS_ERR}, 32'd1);
      for (int i = 0; i < 4; i++) step(0, 0, 3'd4, 0, 0, 0);
      check("ovf_last_ret", PC_OUT, 32'h108);

      // Underflow: RET on empty stack at 0x20 falls through to 0x24.
      step(1, 0, 3'd0, 0, 0, 0);
      step(0, 0, 3'd5, 0, 0, 32'h20);
      step(0, 0, 3'd4, 0, 0, 0);
      check("unf_pc", PC_OUT, 32'h24);
      check("unf_err", {31'd0, RAS_ERR}, 32'd1);

      // Wrap-around of the sequential adder.
      step(0, 0, 3'd5, 0, 0, 32'hFFFF_FFFC);
      step(0, 0, 3'd0, 0, 0, 0);
      check("wrap", PC_OUT, 32'h0);

      // Reset mid-chain discards stack and error flag.
      step(0, 0, 3'd3, 0, 32'h10, 0);
      step(0, 0, 3'd3, 0, 32'h10, 0);
      step(1, 0, 3'd3, 0, 32'h10, 0);
      check("rst_err", {31'd0, RAS_ERR}, 32'd0);
      check("rst_empty", {31'd0, RAS_EMPTY}, 32'd1);

      // Randomized traffic against the reference model.
      for (int i = 0; i < 400; i++) begin
         bit          r_rst;
         bit          r_busy;
         logic [31:0] r_off;
         r_rst  = ($urandom_range(0, 99) < 2);
         r_busy = ($urandom_range(0, 99) < 20);
         r_off  = ($urandom_range(0, 3) == 0) ? $urandom() : {$urandom_range(0, 255) - 32'd128, 2'b00};
         step(r_rst, r_busy, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), r_off, $urandom());
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/pc_seq_unit.md
# pc_seq_unit

Parametrised program-counter sequencer for the 8-bit CPU fetch stage. It is the successor of the fixed PC+4 control unit. It holds the PC register and selects the next PC from five sources: sequential, conditional branch, relative jump, call/return through an internal return-address stack (RAS), and absolute register jump. It sits between the control unit/ALU, which supply mode, condition and offset, and instruction memory, which consumes PC_OUT and raises BUSY while a fetch is pending.

## Interface
- ADDR_W, 32: PC/offset/target width.
- STEP, 4: byte increment per instruction.
- RESET_VEC, -STEP (two's complement in ADDR_W): PC value loaded at reset, so the first un-stalled cycle fetches address 0.
- RAS_DEPTH, 4: return-address stack entries; power of two, at least 2.

- CLK  in  1  clock; all state updates on rising edge.
- RESET  in  1  synchronous, active-high; clock CLK.
- BUSY  in  1  memory busywait; when high, all state (PC, RAS, flags) holds.
- MODE  in  3  next-PC select: SEQ=0, BR=1, JMP=2, CALL=3, RET=4, JR=5; codes 6 and 7 behave as SEQ.
- TAKEN  in  1  branch condition, used only in BR.
- OFFSET  in  ADDR_W  signed byte offset, already sign-extended and scaled by the decoder.
- TARGET  in  ADDR_W  absolute target for JR.
- PC_OUT  out  ADDR_W  current PC (registered).
- RAS_EMPTY  out  1  RAS holds no entries.
- RAS_FULL  out  1  RAS holds RAS_DEPTH entries.
- RAS_ERR  out  1  sticky: set on RAS overflow or underflow, cleared only by RESET.

## Operation
- Define SEQ_PC = PC_OUT + STEP, modulo 2^ADDR_W. Define REL_PC = SEQ_PC + OFFSET, modulo 2^ADDR_W. Carries are dropped and wrap-around is legal.
- Next PC by mode:
  - SEQ: SEQ_PC.
  - BR: REL_PC if TAKEN, else SEQ_PC.
  - JMP: REL_PC.
  - CALL: REL_PC, and push SEQ_PC.
  - RET: the popped top entry. If the RAS is empty, SEQ_PC instead, and RAS_ERR is set.
  - JR: TARGET.
- RAS is a circular buffer with a top pointer and an occupancy count (0..RAS_DEPTH).
  - Push when full: overwrite the oldest entry, count stays at RAS_DEPTH, and RAS_ERR is set.
  - Pop: decrement the count and the pointer.
- RAS_EMPTY = (count==0). RAS_FULL = (count==RAS_DEPTH). Both are combinational from registered count.
- BUSY high: PC_OUT, RAS contents, pointer, count and RAS_ERR all hold. MODE is ignored that cycle.
- Reset values: PC_OUT=RESET_VEC, count=0, pointer=0, RAS_ERR=0, hence RAS_EMPTY=1 and RAS_FULL=0. RAS entry contents are don't-care.

## Timing
- Single-cycle latency: inputs sampled at edge N, and PC_OUT/flags reflect the result after edge N. No internal delays in RTL.
- RESET has priority over BUSY and MODE. Reset in the middle of a call chain discards the RAS.
- Only one RAS operation per cycle, so simultaneous push and pop cannot occur.
- RET reads the top entry combinationally from the registered array. Storage is a register array, not RAM.
- Cycle following deassertion of RESET with BUSY=0: PC_OUT becomes RESET_VEC+STEP (=0 by default).

## Structure
- Shared package `cpu_pkg`: MODE encodings (PC_SEQ, PC_BR, PC_JMP, PC_CALL, PC_RET, PC_JR) and the default STEP constant. The decoder uses the same package.
- One sub-module: `ras_stack` (parameters ADDR_W and RAS_DEPTH).
  - Ports: push, pop, push_data, top_data, empty, full, ovf, unf.
  - Owns the pointer and count.
- `pc_seq_unit` contains the next-PC mux, the adders, the PC register and the sticky error flag.

## Test plan
- Reset then SEQ with BUSY=0 for 3 cycles: PC_OUT goes 0xFFFFFFFC → 0 → 4 → 8; RAS_EMPTY=1.
- At PC=0x10:
  - BR with TAKEN=0, OFFSET=0x20: next PC is 0x14.
  - BR with TAKEN=1, OFFSET=-8: next PC is 0x0C.
  - JR with TARGET=0x100: next PC is 0x100.
- BUSY held high for 3 cycles with MODE=CALL: PC_OUT and the RAS are unchanged. On the first cycle with BUSY low, PC goes to REL_PC and a single push occurs.
- CALL at PC 0x00, 0x40 and 0x80 (OFFSET 0x3C each), then RET three times: PCs return to 0x84, 0x44, 0x04; RAS_EMPTY=1; RAS_ERR=0.
- Five CALLs with RAS_DEPTH=4: RAS_FULL=1 and RAS_ERR=1 after the 5th. Four RETs then return the 5th, 4th, 3rd and 2nd return addresses.
- RET on an empty RAS at PC=0x20: next PC is 0x24 and RAS_ERR=1. Wrap-around check: SEQ at PC=0xFFFFFFFC gives 0. RESET asserted mid-chain clears RAS_ERR and count.
